// File: rtl/key_loader.sv
// key_loader: collects a password byte stream into a zero-padded key buffer.
// The buffer is held for a downstream pbkdf2 controller until it takes it.
// Bytes beyond KEY_BYTES are still accepted, but they are dropped and flagged.
module key_loader #(
  parameter int KEY_BYTES = 128
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic [7:0]             in_data,
  input  logic                   in_last,
  output logic                   in_ready,
  output logic [KEY_BYTES*8-1:0] key,
  output logic [7:0]             key_len,
  output logic                   key_trunc,
  output logic                   key_valid,
  input  logic                   key_ready
);

  localparam int IDX_W = $clog2(KEY_BYTES);

  typedef enum logic [0:0] {
    ST_FILL = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  state_t                      state_r;
  state_t                      state_s;
  logic [0:KEY_BYTES-1][7:0]   buf_r;
  logic [7:0]                  count_r;
  logic                        trunc_r;
  logic                        accept_s;
  logic                        handshake_s;
  logic                        room_s;

  // State register; reset always returns to FILL, discarding any held key.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_FILL;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic plus combinational handshake flags decoded from state.
  always_comb begin
    state_s     = state_r;
    in_ready    = 1'b0;
    key_valid   = 1'b0;
    accept_s    = 1'b0;
    handshake_s = 1'b0;
    case (state_r)
      ST_FILL: begin
        in_ready = 1'b1;
        accept_s = in_valid;
        if (in_valid && in_last) begin
          state_s = ST_HOLD;
        end else begin
          state_s = ST_FILL;
        end
      end
      ST_HOLD: begin
        key_valid   = 1'b1;
        handshake_s = key_ready;
        if (key_ready) begin
          state_s = ST_FILL;
        end else begin
          state_s = ST_HOLD;
        end
      end
      default: begin
        state_s = ST_FILL;
      end
    endcase
  end

  // Saturating room check: count never exceeds KEY_BYTES.
  always_comb begin
    room_s = (count_r < 8'(KEY_BYTES));
  end

  // Key buffer, byte count and sticky truncation flag.
  // The handshake wipes the buffer so a shorter next key reads zero-padded.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buf_r   <= '0;
      count_r <= 8'd0;
      trunc_r <= 1'b0;
    end else if (handshake_s) begin
      buf_r   <= '0;
      count_r <= 8'd0;
      trunc_r <= 1'b0;
    end else if (accept_s) begin
      if (room_s) begin
        buf_r[count_r[IDX_W-1:0]] <= in_data;
        count_r                   <= count_r + 8'd1;
        trunc_r                   <= trunc_r;
      end else begin
        count_r <= count_r;
        trunc_r <= 1'b1;
      end
    end else begin
      buf_r   <= buf_r;
      count_r <= count_r;
      trunc_r <= trunc_r;
    end
  end

  assign key       = buf_r;
  assign key_len   = count_r;
  assign key_trunc = trunc_r;

endmodule

// File: tb/tb_key_loader.sv
// Self-checking bench for key_loader: directed scenarios plus random
// passwords, checked against a queue-based model of the accepted bytes.
module tb_key_loader;

  logic          clk;
  logic          reset;
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_last;
  logic          in_ready;
  logic [1023:0] key;
  logic [7:0]    key_len;
  logic          key_trunc;
  logic          key_valid;
  logic          key_ready;

  int compared;
  int mismatched;

  // Model: every byte accepted for the current password, and the hold flag.
  logic [7:0] pw_q[$];
  bit         m_hold;

  key_loader #(.KEY_BYTES(128)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .key       (key),
    .key_len   (key_len),
    .key_trunc (key_trunc),
    .key_valid (key_valid),
    .key_ready (key_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1023:0] exp_key();
    logic [1023:0] k;
    k = '0;
    for (int i = 0; i < 128; i++) begin
      if (i < pw_q.size()) k[1023 - 8*i -: 8] = pw_q[i];
    end
    return k;
  endfunction

  task automatic check_all(input string tag);
    int n;
    n = (pw_q.size() > 128) ? 128 : pw_q.size();
    cmp({tag, ".key_valid"}, 1024'(key_valid), 1024'(m_hold));
    cmp({tag, ".in_ready"},  1024'(in_ready),  1024'(!m_hold));
    cmp({tag, ".key_len"},   1024'(key_len),   1024'(n));
    cmp({tag, ".key_trunc"}, 1024'(key_trunc), 1024'(pw_q.size() > 128));
    cmp({tag, ".key"},       key,              exp_key());
  endtask

  task automatic model_clear();
    pw_q.delete();
    m_hold = 1'b0;
  endtask

  // One clock: drive at negedge, update model at posedge, check just after.
  task automatic step(input string tag, input logic v, input logic [7:0] d,
                      input logic l, input logic kr);
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    in_last   = l;
    key_ready = kr;
    @(posedge clk);
    if (!m_hold) begin
      if (v) begin
        pw_q.push_back(d);
        if (l) m_hold = 1'b1;
      end
    end else if (kr) begin
      model_clear();
    end
    #1;
    check_all(tag);
  endtask

  // Send a byte list with optional random idle gaps; key_ready randomised (ignored in FILL).
  task automatic send(input string tag, input logic [7:0] bytes[$], input bit gaps);
    for (int i = 0; i < bytes.size(); i++) begin
      if (gaps) begin
        while ($urandom_range(0, 2) == 0)
          step({tag, ".gap"}, 1'b0, 8'($urandom), 1'($urandom), 1'($urandom));
      end
      step(tag, 1'b1, bytes[i], (i == bytes.size() - 1), gaps ? 1'($urandom) : 1'b0);
    end
  endtask

  initial begin
    logic [7:0] bq[$];
    logic [7:0] kb;
    compared   = 0;
    mismatched = 0;
    model_clear();
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    in_last   = 1'b0;
    key_ready = 1'b0;

    // Reset state
    #12;
    check_all("reset");
    @(negedge clk);
    reset = 1'b0;
    step("post_reset", 1'b0, 8'h00, 1'b0, 1'b1);

    // "teaCher" held stable for 20 cycles while input noise is ignored
    bq = '{8'h74, 8'h65, 8'h61, 8'h43, 8'h68, 8'h65, 8'h72};
    send("teacher", bq, 1'b0);
    cmp("teacher.len_const", 1024'(key_len), 1024'(8'd7));
    for (int i = 0; i < 20; i++)
      step("teacher.hold", 1'($urandom), 8'($urandom), 1'($urandom), 1'b0);

    // Handshake clears; then a 2-byte key shows zero padding
    step("handshake", 1'b0, 8'h00, 1'b0, 1'b1);
    cmp("handshake.key_zero", key, 1024'(0));
    bq = '{8'h41, 8'h42};
    send("ab", bq, 1'b0);
    cmp("ab.top_bytes", 1024'(key[1023 -: 56]), 1024'(56'h4142_0000_0000_00));
    step("ab.release", 1'b0, 8'h00, 1'b0, 1'b1);

    // 130-byte password: truncation at 128, bytes 128/129 accepted and dropped
    bq.delete();
    for (int n = 0; n < 130; n++) bq.push_back(8'(n));
    send("trunc", bq, 1'b0);
    kb = key[7:0];
    cmp("trunc.byte127", 1024'(kb), 1024'(8'h7F));
    cmp("trunc.flag", 1024'(key_trunc), 1024'(1'b1));
    step("trunc.release", 1'b0, 8'h00, 1'b0, 1'b1);

    // 5-byte stream with random valid gaps
    bq.delete();
    for (int n = 0; n < 5; n++) bq.push_back(8'($urandom));
    send("gappy5", bq, 1'b1);
    cmp("gappy5.len", 1024'(key_len), 1024'(8'd5));
    step("gappy5.release", 1'b0, 8'h00, 1'b0, 1'b1);

    // Asynchronous reset mid-cycle after 3 accepted bytes
    for (int n = 0; n < 3; n++) step("pre_areset", 1'b1, 8'($urandom_range(1, 255)), 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    model_clear();
    check_all("areset.immediate");
    @(negedge clk);
    reset = 1'b0;
    step("areset.one", 1'b1, 8'hA5, 1'b1, 1'b0);
    cmp("areset.key0", 1024'(key[1023 -: 8]), 1024'(8'hA5));

    // Reset coincident with key_ready while holding: reset wins
    @(negedge clk);
    key_ready = 1'b1;
    reset     = 1'b1;
    @(posedge clk);
    model_clear();
    #1;
    check_all("hold_reset");
    @(negedge clk);
    reset     = 1'b0;
    key_ready = 1'b0;
    step("hold_reset.after", 1'b0, 8'h00, 1'b0, 1'b1);

    // Random passwords with random lengths, gaps and release delays
    for (int p = 0; p < 6; p++) begin
      int len;
      len = (p == 0) ? 128 : (p == 1) ? 1 : $urandom_range(1, 140);
      bq.delete();
      for (int n = 0; n < len; n++) bq.push_back(8'($urandom));
      send("rand", bq, 1'b1);
      for (int w = $urandom_range(0, 3); w > 0; w--)
        step("rand.wait", 1'($urandom), 8'($urandom), 1'($urandom), 1'b0);
      step("rand.release", 1'($urandom), 8'($urandom), 1'($urandom), 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
